shell_unit: RTL and testbench

- Per-player shell manager that sits directly upstream of the VGA renderer and feeds its `i_is_shell_1` / `i_is_shell_2` inputs.
- Holds up to MAX_SHELLS shell positions on the 64x44 game grid.
- Answers the renderer's per-grid `(request_x, request_y)` query with a registered hit flag.
- Moves, spawns and retires shells only while the renderer is not busy (`i_buzy` low). Wall checks go through a dedicated read port on the map.

---
 rtl/game_pkg.sv | 51 +++++
 rtl/shell_match.sv | 37 +++
 rtl/shell_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_shell_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: grid size, play state code, heading encoding,
// FSM state encoding for the shell manager and the one-cell step helper.
package game_pkg;

    localparam int GRID_W = 64;
    localparam int GAME_H = 44;

    localparam logic [1:0] STATE_PLAY = 2'd1;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_SPAWN = 3'd4,
        S_SWAIT = 3'd5,
        S_SCHK  = 3'd6
    } shell_state_t;

    typedef struct packed {
        logic       oob;
        logic [5:0] x;
        logic [5:0] y;
    } cell_step_t;

    // Next cell one step along dir; oob is set when the step would leave the grid.
    function automatic cell_step_t step(input logic [5:0] x, input logic [5:0] y, input dir_t dir,
                                        input logic [5:0] max_x = 6'(GRID_W - 1),
                                        input logic [5:0] max_y = 6'(GAME_H - 1));
        cell_step_t r;
        r.oob = 1'b0;
        r.x   = x;
        r.y   = y;
        case (dir)
            UP:    if (y == 6'd0)  r.oob = 1'b1; else r.y = y - 6'd1;
            RIGHT: if (x == max_x) r.oob = 1'b1; else r.x = x + 6'd1;
            DOWN:  if (y == max_y) r.oob = 1'b1; else r.y = y + 6'd1;
            LEFT:  if (x == 6'd0)  r.oob = 1'b1; else r.x = x - 6'd1;
            default: r.oob = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shell_match.sv
// Registered hit detector: flags whether any active slot sits on the query cell.
// One cycle of latency, independent of whatever else the owner is doing.
module shell_match
    import game_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0][5:0]   slot_x,
    input  logic [N-1:0][5:0]   slot_y,
    input  logic [N-1:0]        active,
    input  logic [5:0]          req_x,
    input  logic [5:0]          req_y,
    output logic                hit
);

    logic hit_s;
    logic hit_r;

    // OR of per-slot position matches over the active slots.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            hit_s = hit_s | (active[i] & (slot_x[i] == req_x) & (slot_y[i] == req_y));
        end
    end

    // Register the match so the renderer sees it exactly one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hit_r <= 1'b0;
        else        hit_r <= hit_s;
    end

    assign hit = hit_r;

endmodule

// File: rtl/shell_unit.sv
// Per-player shell manager. Shells advance one cell every MOVE_PERIOD frames,
// are retired on leaving the grid or hitting a wall, and new shells spawn in
// front of the tank on a latched fire request. All updates run in the short
// window right after the renderer drops its busy flag.
module shell_unit
    import game_pkg::*;
#(
    parameter int WIDTH       = GRID_W,
    parameter int GAME_HEIGHT = GAME_H,
    parameter int MAX_SHELLS  = 4,
    parameter int MOVE_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_state,
    input  logic                  i_buzy,
    input  logic                  i_fire,
    input  logic [5:0]            i_tank_x,
    input  logic [5:0]            i_tank_y,
    input  logic [1:0]            i_tank_dir,
    input  logic [5:0]            i_request_x,
    input  logic [5:0]            i_request_y,
    output logic                  o_is_shell,
    output logic [5:0]            o_wall_x,
    output logic [5:0]            o_wall_y,
    input  logic                  i_is_wall,
    output logic [MAX_SHELLS-1:0] o_active,
    output logic                  o_fire_ack
);

    localparam int IDX_W = (MAX_SHELLS > 1) ? $clog2(MAX_SHELLS) : 1;
    localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SHELLS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MOVE_PERIOD - 1);
    localparam logic [5:0]       MAX_X    = 6'(WIDTH - 1);
    localparam logic [5:0]       MAX_Y    = 6'(GAME_HEIGHT - 1);

    // Slot storage and control state
    logic [MAX_SHELLS-1:0][5:0] slot_x_r;
    logic [MAX_SHELLS-1:0][5:0] slot_y_r;
    dir_t [MAX_SHELLS-1:0]      slot_dir_r;
    logic [MAX_SHELLS-1:0]      active_r;
    shell_state_t               state_r, state_nxt_s;
    logic [IDX_W-1:0]           idx_r, idx_nxt_s;
    logic [CNT_W-1:0]           frame_cnt_r;
    logic                       buzy_d_r;
    logic                       pending_r;
    logic                       fire_ack_r;
    logic [5:0]                 wall_x_r, wall_y_r;
    dir_t                       spawn_dir_r;

    // Decoded control
    logic       play_s, frame_edge_s, move_frame_s, last_slot_s;
    logic       free_any_s;
    logic [IDX_W-1:0] free_idx_s;
    cell_step_t cur_step_s, spawn_step_s;
    logic       wall_load_s, spawn_dir_ld_s, clear_s, commit_s, spawn_s, pend_clr_s, ack_s;
    logic [5:0] wall_x_nxt_s, wall_y_nxt_s;

    assign play_s       = (i_state == STATE_PLAY);
    assign frame_edge_s = buzy_d_r & ~i_buzy;
    assign move_frame_s = frame_edge_s & (frame_cnt_r == LAST_CNT);
    assign last_slot_s  = (idx_r == LAST_IDX);
    assign cur_step_s   = step(slot_x_r[idx_r], slot_y_r[idx_r], slot_dir_r[idx_r], MAX_X, MAX_Y);
    assign spawn_step_s = step(i_tank_x, i_tank_y, dir_t'(i_tank_dir), MAX_X, MAX_Y);

    // Lowest-numbered free slot; scanning downward lets the lowest index win.
    always_comb begin
        free_any_s = 1'b0;
        free_idx_s = {IDX_W{1'b0}};
        for (int i = MAX_SHELLS - 1; i >= 0; i--) begin
            free_idx_s = active_r[i] ? free_idx_s : IDX_W'(i);
            free_any_s = free_any_s | ~active_r[i];
        end
    end

    // FSM state and slot cursor; leaving PLAY abandons any update in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            idx_r   <= {IDX_W{1'b0}};
        end else if (!play_s) begin
            state_r <= S_IDLE;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state decode plus the strobes that drive the slot datapath.
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        wall_load_s    = 1'b0;
        wall_x_nxt_s   = wall_x_r;
        wall_y_nxt_s   = wall_y_r;
        spawn_dir_ld_s = 1'b0;
        clear_s        = 1'b0;
        commit_s       = 1'b0;
        spawn_s        = 1'b0;
        pend_clr_s     = 1'b0;
        ack_s          = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (frame_edge_s) begin
                    state_nxt_s = move_frame_s ? S_SCAN : S_SPAWN;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SCAN: begin
                if (!active_r[idx_r] || cur_step_s.oob) begin
                    // Out-of-grid shells retire here without touching the map port.
                    clear_s     = active_r[idx_r];
                    state_nxt_s = last_slot_s ? S_SPAWN : S_SCAN;
                    idx_nxt_s   = last_slot_s ? idx_r : idx_r + IDX_W'(1);
                end else begin
                    wall_load_s  = 1'b1;
                    wall_x_nxt_s = cur_step_s.x;
                    wall_y_nxt_s = cur_step_s.y;
                    state_nxt_s  = S_WAIT;
                end
            end
            S_WAIT: state_nxt_s = S_CHECK;
            S_CHECK: begin
                if (i_is_wall) clear_s  = 1'b1;
                else           commit_s = 1'b1;
                state_nxt_s = last_slot_s ? S_SPAWN : S_SCAN;
                idx_nxt_s   = last_slot_s ? idx_r : idx_r + IDX_W'(1);
            end
            S_SPAWN: begin
                if (!pending_r) begin
                    state_nxt_s = S_IDLE;
                end else if (!free_any_s || spawn_step_s.oob) begin
                    pend_clr_s  = 1'b1;
                    state_nxt_s = S_IDLE;
                end else begin
                    wall_load_s    = 1'b1;
                    wall_x_nxt_s   = spawn_step_s.x;
                    wall_y_nxt_s   = spawn_step_s.y;
                    spawn_dir_ld_s = 1'b1;
                    state_nxt_s    = S_SWAIT;
                end
            end
            S_SWAIT: state_nxt_s = S_SCHK;
            S_SCHK: begin
                if (!i_is_wall) begin
                    spawn_s = 1'b1;
                    ack_s   = 1'b1;
                end else begin
                    spawn_s = 1'b0;
                end
                pend_clr_s  = 1'b1;
                state_nxt_s = S_IDLE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Slot array, fire latch, frame counter, wall-query address and ack pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_x_r    <= '0;
            slot_y_r    <= '0;
            slot_dir_r  <= {MAX_SHELLS{UP}};
            active_r    <= {MAX_SHELLS{1'b0}};
            frame_cnt_r <= {CNT_W{1'b0}};
            buzy_d_r    <= 1'b0;
            pending_r   <= 1'b0;
            fire_ack_r  <= 1'b0;
            wall_x_r    <= 6'd0;
            wall_y_r    <= 6'd0;
            spawn_dir_r <= UP;
        end else begin
            buzy_d_r <= i_buzy;
            if (!play_s) begin
                active_r    <= {MAX_SHELLS{1'b0}};
                frame_cnt_r <= {CNT_W{1'b0}};
                pending_r   <= 1'b0;
                fire_ack_r  <= 1'b0;
            end else begin
                if (frame_edge_s) begin
                    frame_cnt_r <= move_frame_s ? {CNT_W{1'b0}} : frame_cnt_r + CNT_W'(1);
                end
                // A fresh pulse re-arms even on the cycle the old request is consumed.
                pending_r  <= i_fire | (pending_r & ~pend_clr_s);
                fire_ack_r <= ack_s;
                if (wall_load_s) begin
                    wall_x_r <= wall_x_nxt_s;
                    wall_y_r <= wall_y_nxt_s;
                end
                if (spawn_dir_ld_s) spawn_dir_r <= dir_t'(i_tank_dir);
                if (clear_s) active_r[idx_r] <= 1'b0;
                if (commit_s) begin
                    slot_x_r[idx_r] <= wall_x_r;
                    slot_y_r[idx_r] <= wall_y_r;
                end
                if (spawn_s) begin
                    active_r[free_idx_s]   <= 1'b1;
                    slot_x_r[free_idx_s]   <= wall_x_r;
                    slot_y_r[free_idx_s]   <= wall_y_r;
                    slot_dir_r[free_idx_s] <= spawn_dir_r;
                end
            end
        end
    end

    shell_match #(.N(MAX_SHELLS)) u_match (
        .clk    (clk),
        .rst_n  (rst_n),
        .slot_x (slot_x_r),
        .slot_y (slot_y_r),
        .active (active_r),
        .req_x  (i_request_x),
        .req_y  (i_request_y),
        .hit    (o_is_shell)
    );

    assign o_wall_x   = wall_x_r;
    assign o_wall_y   = wall_y_r;
    assign o_active   = active_r;
    assign o_fire_ack = fire_ack_r;

endmodule

// File: tb/tb_shell_unit.sv
// Directed bench for shell_unit: spawn, movement cadence, wall and edge
// retirement, full slot table, leaving PLAY and reset during an update.
module tb_shell_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] i_state;
    logic       i_buzy;
    logic       i_fire;
    logic [5:0] i_tank_x, i_tank_y;
    logic [1:0] i_tank_dir;
    logic [5:0] i_request_x, i_request_y;
    logic       o_is_shell;
    logic [5:0] o_wall_x, o_wall_y;
    logic       i_is_wall;
    logic [3:0] o_active;
    logic       o_fire_ack;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;

    always #5 clk = ~clk;

    shell_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_state     (i_state),
        .i_buzy      (i_buzy),
        .i_fire      (i_fire),
        .i_tank_x    (i_tank_x),
        .i_tank_y    (i_tank_y),
        .i_tank_dir  (i_tank_dir),
        .i_request_x (i_request_x),
        .i_request_y (i_request_y),
        .o_is_shell  (o_is_shell),
        .o_wall_x    (o_wall_x),
        .o_wall_y    (o_wall_y),
        .i_is_wall   (i_is_wall),
        .o_active    (o_active),
        .o_fire_ack  (o_fire_ack)
    );

    // Map model: single wall at (21,5), answered one cycle after the address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) i_is_wall <= 1'b0;
        else        i_is_wall <= (o_wall_x == 6'd21) && (o_wall_y == 6'd5);
    end

    // Count spawn acknowledges.
    always @(negedge clk) begin
        if (o_fire_ack === 1'b1) ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fire(input logic [5:0] tx, input logic [5:0] ty, input logic [1:0] td);
        @(negedge clk);
        i_tank_x = tx; i_tank_y = ty; i_tank_dir = td; i_fire = 1'b1;
        @(negedge clk);
        i_fire = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk); i_buzy = 1'b1;
        @(negedge clk); i_buzy = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic query(input string tag, input logic [5:0] qx, input logic [5:0] qy, input logic exp);
        @(negedge clk);
        i_request_x = qx; i_request_y = qy;
        @(negedge clk);
        check(tag, {31'd0, o_is_shell}, {31'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; i_state = 2'd1; i_buzy = 1'b0; i_fire = 1'b0;
        i_tank_x = 6'd0; i_tank_y = 6'd0; i_tank_dir = 2'd0;
        i_request_x = 6'd0; i_request_y = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_is_shell", {31'd0, o_is_shell}, 32'd0);
        check("rst_ack",      {31'd0, o_fire_ack}, 32'd0);
        check("rst_wall_x",   {26'd0, o_wall_x},   32'd0);
        check("rst_wall_y",   {26'd0, o_wall_y},   32'd0);
        check("rst_active",   {28'd0, o_active},   32'd0);
        rst_n = 1'b1;

        // Spawn from (10,10) heading right on a non-move frame.
        fire(6'd10, 6'd10, 2'd1);
        frame();
        check("spawn_ack",    ack_cnt, 32'd1);
        check("spawn_active", {28'd0, o_active}, 32'h1);
        check("spawn_wall_x", {26'd0, o_wall_x}, 32'd11);
        check("spawn_wall_y", {26'd0, o_wall_y}, 32'd10);
        query("hit_11_10", 6'd11, 6'd10, 1'b1);
        query("miss_12_10", 6'd12, 6'd10, 1'b0);

        // Second frame is a move frame: shell steps to (12,10).
        frame();
        query("move_12_10", 6'd12, 6'd10, 1'b1);
        query("move_old_11_10", 6'd11, 6'd10, 1'b0);
        check("move_wall_x", {26'd0, o_wall_x}, 32'd12);

        // Non-move frame: stays at (12,10).
        frame();
        query("hold_12_10", 6'd12, 6'd10, 1'b1);

        // Spawn (20,5) heading right during a move frame; slot 0 goes to (13,10).
        fire(6'd19, 6'd5, 2'd1);
        frame();
        check("spawn2_active", {28'd0, o_active}, 32'h3);
        check("spawn2_ack", ack_cnt, 32'd2);
        query("hit_20_5", 6'd20, 6'd5, 1'b1);
        frame();                                   // non-move
        frame();                                   // move: (21,5) is a wall
        check("wall_q_x", {26'd0, o_wall_x}, 32'd21);
        check("wall_q_y", {26'd0, o_wall_y}, 32'd5);
        check("wall_clear_active", {28'd0, o_active}, 32'h1);
        query("slot0_14_10", 6'd14, 6'd10, 1'b1);

        // Shell at the right edge retires without a wall query.
        fire(6'd62, 6'd7, 2'd1);
        frame();                                   // non-move: spawn (63,7) in slot 1
        check("edge_spawn_active", {28'd0, o_active}, 32'h3);
        frame();                                   // move: slot0 -> (15,10), slot1 out
        check("edge_active", {28'd0, o_active}, 32'h1);
        check("edge_wall_x", {26'd0, o_wall_x}, 32'd15);
        check("edge_wall_y", {26'd0, o_wall_y}, 32'd10);

        // Fill all four slots, then a fifth request is dropped.
        fire(6'd30, 6'd30, 2'd2);
        frame();                                   // non-move
        fire(6'd30, 6'd30, 2'd2);
        frame();                                   // move
        fire(6'd30, 6'd30, 2'd2);
        frame();                                   // non-move
        check("full_active", {28'd0, o_active}, 32'hF);
        check("full_ack", ack_cnt, 32'd6);
        fire(6'd30, 6'd30, 2'd2);
        frame();                                   // move, spawn dropped
        check("drop_ack", ack_cnt, 32'd6);
        check("drop_active", {28'd0, o_active}, 32'hF);
        query("full_30_33", 6'd30, 6'd33, 1'b1);
        query("full_30_32", 6'd30, 6'd32, 1'b1);
        query("full_17_10", 6'd17, 6'd10, 1'b1);

        // Leaving PLAY clears the table on the next clock.
        @(negedge clk); i_state = 2'd0;
        @(negedge clk);
        check("notplay_active", {28'd0, o_active}, 32'h0);
        @(negedge clk);
        check("notplay_is_shell", {31'd0, o_is_shell}, 32'd0);

        // Reset asserted while the FSM sits in CHECK.
        @(negedge clk); i_state = 2'd1;
        fire(6'd10, 6'd10, 2'd1);
        frame();                                   // non-move: spawn (11,10)
        check("re_spawn_ack", ack_cnt, 32'd7);
        @(negedge clk); i_buzy = 1'b1;
        @(negedge clk); i_buzy = 1'b0;
        repeat (3) @(negedge clk);                 // SCAN, WAIT, CHECK
        check("pre_rst_wall_x", {26'd0, o_wall_x}, 32'd12);
        rst_n = 1'b0;
        #1;
        check("midrst_active", {28'd0, o_active},   32'd0);
        check("midrst_wall_x", {26'd0, o_wall_x},   32'd0);
        check("midrst_wall_y", {26'd0, o_wall_y},   32'd0);
        check("midrst_ack",    {31'd0, o_fire_ack}, 32'd0);
        check("midrst_hit",    {31'd0, o_is_shell}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("postrst_active", {28'd0, o_active}, 32'd0);
        fire(6'd10, 6'd10, 2'd1);
        frame();
        check("postrst_ack", ack_cnt, 32'd8);
        check("postrst_active2", {28'd0, o_active}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
